// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table builder and FSM state type for the CORDIC atan2 unit.
// Angles are signed degrees scaled by 2^FRAC.
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, ROT, HOLD} state_t;

    localparam int LUT_N        = 24;
    localparam int BASE_FRAC    = 20;
    localparam int DEFAULT_FRAC = 8;

    typedef logic [LUT_N-1:0][31:0] lut_t;

    // atan(2^-i) in degrees * 2^20, rounded; rescaled to the requested FRAC below.
    function automatic logic [31:0] atan_base(input int i);
        case (i)
            0:  return 32'd47185920;
            1:  return 32'd27855475;
            2:  return 32'd14718068;
            3:  return 32'd7471121;
            4:  return 32'd3750058;
            5:  return 32'd1876857;
            6:  return 32'd938658;
            7:  return 32'd469357;
            8:  return 32'd234682;
            9:  return 32'd117342;
            10: return 32'd58671;
            11: return 32'd29335;
            12: return 32'd14668;
            13: return 32'd7334;
            14: return 32'd3667;
            15: return 32'd1833;
            16: return 32'd917;
            17: return 32'd458;
            18: return 32'd229;
            19: return 32'd115;
            20: return 32'd57;
            21: return 32'd29;
            22: return 32'd14;
            23: return 32'd7;
            default: return 32'd0;
        endcase
    endfunction

    function automatic lut_t build_atan_lut(input int frac);
        lut_t lut;
        for (int i = 0; i < LUT_N; i++) begin
            if (frac >= BASE_FRAC)
                lut[i] = atan_base(i) << (frac - BASE_FRAC);
            else
                lut[i] = (atan_base(i) + (32'd1 << (BASE_FRAC - 1 - frac))) >> (BASE_FRAC - frac);
        end
        return lut;
    endfunction

    localparam lut_t ATAN_LUT = build_atan_lut(DEFAULT_FRAC);

    function automatic int deg90(input int frac);
        return 90 << frac;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational vectoring-mode micro-rotation: drives y towards zero and
// accumulates the rotated angle into z.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int XW   = 22,
    parameter int ZW   = 20,
    parameter int FRAC = 8
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [4:0]    iter_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    localparam lut_t LUT = (FRAC == DEFAULT_FRAC) ? ATAN_LUT : build_atan_lut(FRAC);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] atan_v;

    always_comb begin
        x_sh   = x_i >>> iter_i;
        y_sh   = y_i >>> iter_i;
        atan_v = ZW'($signed(LUT[iter_i]));
        if (!y_i[XW-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_v;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_v;
        end
    end

endmodule

// File: rtl/cordic_atan2.sv
// Iterative four-quadrant atan2 with uncompensated magnitude, one micro-rotation per cycle.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid never depends on ready.
module cordic_atan2
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ANG_W = 18,
    parameter int ITER  = 14,
    parameter int GUARD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ANG_W-1:0] angle_out,
    output logic        [WIDTH+1:0] mag_out
);

    localparam int XW = WIDTH + 2 + GUARD;
    localparam int ZW = ANG_W + 2;
    localparam logic signed [ZW-1:0] Z90  = ZW'(deg90(FRAC));
    localparam logic signed [ZW-1:0] Z180 = ZW'(2 * deg90(FRAC));

    state_t state_q, state_d;
    logic [4:0] iter_q, iter_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic zero_q, zero_d;
    logic signed [ANG_W-1:0] angle_q, angle_d;
    logic [WIDTH+1:0] mag_q, mag_d;

    logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre, x_nx, y_nx;
    logic signed [ZW-1:0] z_pre, z_nx, z_sat;

    // Fold the left half-plane into the right so the iterations only cover +/-99.9 degrees.
    always_comb begin
        x_ext = XW'(x_in) <<< GUARD;
        y_ext = XW'(y_in) <<< GUARD;
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_ext[XW-1]) begin
            if (!y_ext[XW-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = Z90;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = -Z90;
            end
        end
    end

    cordic_stage #(.XW(XW), .ZW(ZW), .FRAC(FRAC)) u_stage (
        .x_i   (x_q),
        .y_i   (y_q),
        .z_i   (z_q),
        .iter_i(iter_q),
        .x_o   (x_nx),
        .y_o   (y_nx),
        .z_o   (z_nx)
    );

    always_comb begin
        z_sat = z_nx;
        if (z_nx > Z180)
            z_sat = Z180;
        else if (z_nx < -Z180)
            z_sat = -Z180;
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_pre;
                    y_d     = y_pre;
                    z_d     = z_pre;
                    iter_d  = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = ROT;
                end
            end
            ROT: begin
                x_d    = x_nx;
                y_d    = y_nx;
                z_d    = z_nx;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(ITER - 1)) begin
                    // A null vector would otherwise accumulate every table entry.
                    angle_d = zero_q ? '0 : ANG_W'(z_sat);
                    mag_d   = (WIDTH+2)'(x_nx >>> GUARD);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == HOLD);
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_atan2.sv
// Bench for cordic_atan2: real-valued atan2/magnitude model, per-cycle compare process,
// directed boundary vectors with literal expectations, and randomized traffic.
module tb_cordic_atan2;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int ANG_W = 18;
    localparam int ITER  = 14;
    localparam int GUARD = 4;
    localparam real PI   = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic signed [WIDTH-1:0] x_in = '0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic signed [ANG_W-1:0] angle_out;
    logic [WIDTH+1:0] mag_out;

    int checks = 0;
    int errors = 0;
    int n_results = 0;
    logic [31:0] exp_q[$];
    longint last_angle, last_mag;
    real cordic_gain;
    bit rand_phase = 1'b0;

    always #5 clk = ~clk;

    cordic_atan2 #(.WIDTH(WIDTH), .FRAC(FRAC), .ANG_W(ANG_W), .ITER(ITER), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .angle_out(angle_out),
        .mag_out  (mag_out)
    );

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint model_angle(input int x, input int y);
        real rx = x;
        real ry = y;
        if (x == 0 && y == 0) return 0;
        return longint'($atan2(ry, rx) * 180.0 / PI * real'(1 << FRAC));
    endfunction

    function automatic longint model_mag(input int x, input int y);
        real rx = x;
        real ry = y;
        return longint'($floor($sqrt(rx * rx + ry * ry) * cordic_gain));
    endfunction

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint req, input longint tol);
        check(name, absl(act - req) <= tol, act, req);
    endtask

    // Compare process: every cycle out_valid is high the held result is checked against the model.
    int cx, cy;
    longint ea, em;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1'b0, 1, 0);
                end else begin
                    cx = int'($signed(exp_q[0][31:16]));
                    cy = int'($signed(exp_q[0][15:0]));
                    ea = model_angle(cx, cy);
                    em = model_mag(cx, cy);
                    check_near("model_angle", angle_out, ea, 8);
                    check_near("model_mag", mag_out, em, 3);
                    if (out_ready) begin
                        last_angle = angle_out;
                        last_mag   = mag_out;
                        n_results++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back({x_in, y_in});
        end
    end

    task automatic send(input int x, input int y);
        int n = 0;
        bit acc = 1'b0;
        x_in = WIDTH'(x);
        y_in = WIDTH'(y);
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 1'b0, 0, 1);
    endtask

    task automatic wait_result(input int n0);
        int n = 0;
        while (n_results == n0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_results == n0) check("result_timeout", 1'b0, 0, 1);
    endtask

    task automatic run(input int x, input int y);
        int n0 = n_results;
        send(x, y);
        wait_result(n0);
    endtask

    function automatic int rand_comp();
        int v = int'($urandom_range(64, 32767));
        return $urandom_range(0, 1) ? -v : v;
    endfunction

    initial begin
        int e, n0, seen;
        cordic_gain = 1.0;
        for (int i = 0; i < ITER; i++)
            cordic_gain = cordic_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready == 1'b0, in_ready, 0);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_angle", angle_out == '0, angle_out, 0);
        check("rst_mag", mag_out == '0, mag_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready == 1'b1, in_ready, 1);
        @(posedge clk);
        #1;

        // First vector and latency: out_valid is first sampled high at edge ITER+1 after acceptance
        out_ready = 1'b1;
        n0 = n_results;
        send(256, 256);
        e = 0;
        while (e < 100) begin
            @(negedge clk);
            if (out_valid) break;
            e++;
        end
        check("latency", (e + 1) == (ITER + 1), e + 1, ITER + 1);
        wait_result(n0);
        check_near("diag_angle", last_angle, 11520, 8);
        check_near("diag_mag", last_mag, 596, 2);

        // Axis and quadrant vectors
        run(256, 0);     check_near("pos_x_axis", last_angle, 0, 8);
        run(0, 256);     check_near("pos_y_axis", last_angle, 23040, 8);
        run(-256, 0);    check_near("neg_x_axis", last_angle, 46080, 8);
        check("neg_x_not_neg180", last_angle > 0, last_angle, 46080);
        run(-256, -256); check_near("third_quad", last_angle, -34560, 8);
        run(0, -256);    check_near("neg_y_axis", last_angle, -23040, 8);
        run(0, 0);
        check("zero_angle", last_angle == 0, last_angle, 0);
        check("zero_mag", last_mag == 0, last_mag, 0);

        // Extremes
        run(-32768, -32768); check_near("ext_third_quad", last_angle, -34560, 8);
        run(32767, -32768);  check_near("ext_fourth_quad", last_angle, -11520, 8);

        // Sweep against the single-argument arctan convention, then the left half-plane
        for (int y = -2048; y <= 2048; y += 16) begin
            run(256, y);
            check_near("sweep_atan", last_angle,
                       longint'(256.0 * $atan(real'(y) / 256.0) * 57.29577951308), 8);
        end
        for (int y = -2048; y <= 2048; y += 16)
            run(-256, y);

        // Backpressure: outputs held, no new acceptance
        out_ready = 1'b0;
        send(300, -500);
        e = 0;
        while (!out_valid && e < 100) begin
            @(negedge clk);
            e++;
        end
        check("bp_valid_seen", out_valid == 1'b1, out_valid, 1);
        @(posedge clk);
        #1;
        x_in = 16'sd1000;
        y_in = 16'sd1000;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid == 1'b1, out_valid, 1);
            check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_valid", out_valid == 1'b0, out_valid, 0);
        check("bp_release_ready", in_ready == 1'b1, in_ready, 1);
        check_near("bp_angle", last_angle, -15113, 8);

        // Reset in the fifth ROT cycle discards the operation
        @(posedge clk);
        #1;
        send(500, 700);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_valid", out_valid == 1'b0, out_valid, 0);
        check("mid_rst_angle", angle_out == '0, angle_out, 0);
        check("mid_rst_mag", mag_out == '0, mag_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready == 1'b1, in_ready, 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_stale_result", seen == 0, seen, 0);

        // Randomized traffic with random consumer stalls
        @(posedge clk);
        #1;
        rand_phase = 1'b1;
        fork
            begin
                for (int k = 0; k < 120; k++)
                    send(rand_comp(), rand_comp());
                e = 0;
                while ((exp_q.size() != 0 || out_valid) && e < 500) begin
                    @(posedge clk);
                    #1;
                    e++;
                end
                check("drain", exp_q.size() == 0, exp_q.size(), 0);
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
